// File: rtl/mem_burst_master_if.sv
// Client request/data handshake plus mainMem bus for mem_burst_master.
interface mem_burst_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [0:31] req_addr;
   logic        req_write;
   logic [0:1]  req_size;
   logic [0:31] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [0:31] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        done;
   logic        err;
   logic [0:31] mem_addr;
   logic [0:31] mem_data_in;
   logic [0:31] mem_data_out;
   logic [0:1]  mem_acc_size;
   logic        mem_wren;
   logic        mem_enable;
   logic        mem_busy;

   modport master (
      input  req_valid, req_addr, req_write, req_size, wr_data, wr_valid,
             mem_data_out, mem_busy,
      output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
             mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );

   modport slave (
      output req_valid, req_addr, req_write, req_size, wr_data, wr_valid,
             mem_data_out, mem_busy,
      input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err,
             mem_addr, mem_data_in, mem_acc_size, mem_wren, mem_enable
   );
endinterface

// File: rtl/mem_burst_master.sv
// Burst engine in front of mainMem: stages write bursts in a 16-word
// buffer so they go out on back-to-back cycles, and streams read bursts
// back to the client with a fixed memory read latency.
module mem_burst_master #(
   parameter logic [31:0] START_ADDRESS = 32'h80020000,
   parameter int          MEM_WORDS     = 262144,
   parameter int          READ_LATENCY  = 2
) (
   input logic                 clock,
   input logic                 reset_n,
   mem_burst_master_if.master  bus
);

   typedef enum logic [3:0] {
      IDLE, WR_FILL, WR_WAIT, WR_BURST, RD_WAIT,
      RD_ISSUE, RD_LAT, RD_BURST, DONE, ERR
   } state_t;

   // End of the legal window, one bit wider so a request near 4 GB cannot wrap.
   localparam logic [32:0] WINDOW_END = {1'b0, START_ADDRESS} + (33'(MEM_WORDS) << 2);
   // RD_LAT lasts READ_LATENCY-1 cycles (latency must be at least 2).
   localparam logic [4:0]  LAT_LAST   = 5'(READ_LATENCY - 2);

   state_t      r_state;
   logic [0:31] r_addr;
   logic [0:1]  r_size;
   logic [4:0]  r_len;
   logic [4:0]  r_cnt;
   logic [0:31] r_buf [16];

   logic [4:0]  w_reqLen;
   logic [32:0] w_reqEnd;
   logic        w_reqBad;

   function automatic logic [4:0] sizeToLen(input logic [0:1] size);
      case (size)
         2'b00:   return 5'd1;
         2'b01:   return 5'd4;
         2'b10:   return 5'd8;
         default: return 5'd16;
      endcase
   endfunction

   // Reject misaligned, below-window or past-window requests before any memory activity.
   always_comb begin
      w_reqLen = sizeToLen(bus.req_size);
      w_reqEnd = {1'b0, bus.req_addr} + {26'd0, w_reqLen, 2'b00};
      w_reqBad = (bus.req_addr[30:31] != 2'b00)
               || ({1'b0, bus.req_addr} < {1'b0, START_ADDRESS})
               || (w_reqEnd > WINDOW_END);
   end

   // Write staging buffer; contents are don't-care until filled, so no reset.
   always_ff @(posedge clock) begin
      if (r_state == WR_FILL && bus.wr_valid) begin
         r_buf[r_cnt[3:0]] <= bus.wr_data;
      end
   end

   // Main sequencer; every client and memory output is registered here.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state          <= IDLE;
         r_addr           <= '0;
         r_size           <= '0;
         r_len            <= '0;
         r_cnt            <= '0;
         bus.req_ready    <= 1'b0;
         bus.wr_ready     <= 1'b0;
         bus.rd_data      <= '0;
         bus.rd_valid     <= 1'b0;
         bus.rd_last      <= 1'b0;
         bus.done         <= 1'b0;
         bus.err          <= 1'b0;
         bus.mem_addr     <= '0;
         bus.mem_data_in  <= '0;
         bus.mem_acc_size <= '0;
         bus.mem_wren     <= 1'b0;
         bus.mem_enable   <= 1'b0;
      end else begin
         bus.mem_enable <= 1'b1;
         case (r_state)
            IDLE: begin
               bus.req_ready <= 1'b1;
               if (bus.req_valid && bus.req_ready) begin
                  bus.req_ready <= 1'b0;
                  r_addr        <= bus.req_addr;
                  r_size        <= bus.req_size;
                  r_len         <= w_reqLen;
                  r_cnt         <= '0;
                  if (w_reqBad) begin
                     bus.err <= 1'b1;
                     r_state <= ERR;
                  end else if (bus.req_write) begin
                     bus.wr_ready <= 1'b1;
                     r_state      <= WR_FILL;
                  end else begin
                     r_state <= RD_WAIT;
                  end
               end
            end
            WR_FILL: begin
               if (bus.wr_valid) begin
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == r_len - 5'd1) begin
                     bus.wr_ready <= 1'b0;
                     r_state      <= WR_WAIT;
                  end
               end
            end
            WR_WAIT: begin
               if (!bus.mem_busy) begin
                  bus.mem_wren     <= 1'b1;
                  bus.mem_addr     <= r_addr;
                  bus.mem_acc_size <= r_size;
                  bus.mem_data_in  <= r_buf[0];
                  r_cnt            <= 5'd1;
                  r_state          <= WR_BURST;
               end
            end
            WR_BURST: begin
               if (r_cnt == r_len) begin
                  bus.mem_wren <= 1'b0;
                  bus.done     <= 1'b1;
                  r_state      <= DONE;
               end else begin
                  bus.mem_data_in <= r_buf[r_cnt[3:0]];
                  r_cnt           <= r_cnt + 5'd1;
               end
            end
            RD_WAIT: begin
               if (!bus.mem_busy) begin
                  bus.mem_wren     <= 1'b0;
                  bus.mem_addr     <= r_addr;
                  bus.mem_acc_size <= r_size;
                  r_state          <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               r_cnt   <= '0;
               r_state <= RD_LAT;
            end
            RD_LAT: begin
               if (r_cnt == LAT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= RD_BURST;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            RD_BURST: begin
               if (r_cnt == r_len) begin
                  bus.rd_valid <= 1'b0;
                  bus.rd_last  <= 1'b0;
                  bus.done     <= 1'b1;
                  r_state      <= DONE;
               end else begin
                  bus.rd_data  <= bus.mem_data_out;
                  bus.rd_valid <= 1'b1;
                  bus.rd_last  <= (r_cnt == r_len - 5'd1);
                  r_cnt        <= r_cnt + 5'd1;
               end
            end
            DONE: begin
               bus.done      <= 1'b0;
               bus.req_ready <= 1'b1;
               r_state       <= IDLE;
            end
            ERR: begin
               bus.err       <= 1'b0;
               bus.req_ready <= 1'b1;
               r_state       <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a small mainMem model.
module tb_mem_burst_master;

   localparam logic [31:0] START = 32'h80020000;

   logic clock;
   logic reset_n;
   int   checkCount;
   int   errorCount;
   int   wrBeat;
   int   eventCount;
   logic [31:0] vec [16];
   logic [31:0] memModel [int];

   mem_burst_master_if bus ();

   mem_burst_master dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic int wordIdx(input logic [31:0] addr);
      return int'((addr - START) >> 2);
   endfunction

   function automatic logic [31:0] memDefault(input int idx);
      return 32'hA5A50000 ^ 32'(idx);
   endfunction

   function automatic int sizeLen(input logic [1:0] size);
      case (size)
         2'b00:   return 1;
         2'b01:   return 4;
         2'b10:   return 8;
         default: return 16;
      endcase
   endfunction

   function automatic logic [31:0] memRead(input int idx);
      if (memModel.exists(idx)) return memModel[idx];
      return memDefault(idx);
   endfunction

   // Memory model: a write burst lands at consecutive words from the held address.
   always @(posedge clock) begin
      if (reset_n && bus.mem_wren) begin
         memModel[wordIdx(bus.mem_addr) + wrBeat] = bus.mem_data_in;
         wrBeat = wrBeat + 1;
      end else begin
         wrBeat = 0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Write burst from vec[]; optional wr_valid gap before beat gapBeat; or read burst expecting vec[].
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [1:0] size,
                                input int gapBeat, input int gapLen, input int busyN);
      int len;
      logic [31:0] prevAddr;
      len = sizeLen(size);
      prevAddr = bus.mem_addr;
      checkOutput("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_write = isWrite;
      bus.req_size  = size;
      bus.mem_busy  = (busyN > 0);
      @(negedge clock);
      bus.req_valid = 1'b0;
      checkOutput("req_ready_taken", 32'(bus.req_ready), 32'd0);
      if (isWrite) begin
         checkOutput("wr_ready_open", 32'(bus.wr_ready), 32'd1);
         for (int k = 0; k < len; k++) begin
            if (k == gapBeat) begin
               bus.wr_valid = 1'b0;
               for (int g = 0; g < gapLen; g++) @(negedge clock);
               checkOutput("wr_ready_gap", 32'(bus.wr_ready), 32'd1);
               checkOutput("wren_gap", 32'(bus.mem_wren), 32'd0);
            end
            bus.wr_data  = vec[k];
            bus.wr_valid = 1'b1;
            @(negedge clock);
         end
         bus.wr_valid = 1'b0;
         checkOutput("wr_ready_closed", 32'(bus.wr_ready), 32'd0);
         checkOutput("wren_pre", 32'(bus.mem_wren), 32'd0);
         @(negedge clock);
         for (int k = 0; k < len; k++) begin
            checkOutput("wren_burst", 32'(bus.mem_wren), 32'd1);
            checkOutput("mem_data_in", bus.mem_data_in, vec[k]);
            checkOutput("mem_addr_wr", bus.mem_addr, addr);
            checkOutput("acc_size_wr", 32'(bus.mem_acc_size), 32'(size));
            checkOutput("done_early_wr", 32'(bus.done), 32'd0);
            @(negedge clock);
         end
         checkOutput("wren_post", 32'(bus.mem_wren), 32'd0);
      end else begin
         for (int i = 0; i < busyN; i++) begin
            @(negedge clock);
            checkOutput("mem_addr_busy", bus.mem_addr, prevAddr);
         end
         bus.mem_busy = 1'b0;
         @(negedge clock);
         checkOutput("mem_addr_rd", bus.mem_addr, addr);
         checkOutput("acc_size_rd", 32'(bus.mem_acc_size), 32'(size));
         checkOutput("wren_rd", 32'(bus.mem_wren), 32'd0);
         bus.mem_data_out = 32'hDEADBEEF;
         @(negedge clock);
         @(negedge clock);
         checkOutput("rd_valid_early", 32'(bus.rd_valid), 32'd0);
         bus.mem_data_out = memRead(wordIdx(addr));
         for (int k = 0; k < len; k++) begin
            @(negedge clock);
            checkOutput("rd_valid", 32'(bus.rd_valid), 32'd1);
            checkOutput("rd_data", bus.rd_data, vec[k]);
            checkOutput("rd_last", 32'(bus.rd_last), (k == len - 1) ? 32'd1 : 32'd0);
            checkOutput("done_early_rd", 32'(bus.done), 32'd0);
            bus.mem_data_out = (k + 1 < len) ? memRead(wordIdx(addr) + k + 1) : 32'hDEADBEEF;
         end
         @(negedge clock);
         checkOutput("rd_valid_post", 32'(bus.rd_valid), 32'd0);
      end
      checkOutput("done_pulse", 32'(bus.done), 32'd1);
      @(negedge clock);
      checkOutput("done_clear", 32'(bus.done), 32'd0);
      checkOutput("req_ready_back", 32'(bus.req_ready), 32'd1);
   endtask

   // Illegal request: one err pulse, no memory write, ready back a cycle later.
   task automatic applyReject(input logic [31:0] addr, input logic [1:0] size);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_write = 1'b1;
      bus.req_size  = size;
      @(negedge clock);
      bus.req_valid = 1'b0;
      checkOutput("err_pulse", 32'(bus.err), 32'd1);
      checkOutput("wren_err", 32'(bus.mem_wren), 32'd0);
      checkOutput("wr_ready_err", 32'(bus.wr_ready), 32'd0);
      @(negedge clock);
      checkOutput("err_clear", 32'(bus.err), 32'd0);
      checkOutput("req_ready_err", 32'(bus.req_ready), 32'd1);
      checkOutput("wren_err2", 32'(bus.mem_wren), 32'd0);
   endtask

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checkCount       = 0;
      errorCount       = 0;
      wrBeat           = 0;
      eventCount       = 0;
      reset_n          = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_addr     = '0;
      bus.req_write    = 1'b0;
      bus.req_size     = '0;
      bus.wr_data      = '0;
      bus.wr_valid     = 1'b0;
      bus.mem_data_out = '0;
      bus.mem_busy     = 1'b0;

      #2;
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
      checkOutput("rst_mem_wren", 32'(bus.mem_wren), 32'd0);
      checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
      checkOutput("rst_rd_data", bus.rd_data, 32'd0);
      checkOutput("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("req_ready_after_rst", 32'(bus.req_ready), 32'd1);
      checkOutput("mem_enable_on", 32'(bus.mem_enable), 32'd1);

      // Single word write then read.
      vec[0] = 32'h27BDFFE8;
      applyStimulus(1'b1, 32'h80020000, 2'b00, -1, 0, 0);
      applyStimulus(1'b0, 32'h80020000, 2'b00, -1, 0, 0);

      // Four words with a 2-cycle wr_valid gap before beat 2.
      for (int k = 0; k < 4; k++) vec[k] = 32'h11111111 * 32'(k + 1);
      applyStimulus(1'b1, 32'h80020004, 2'b01, 2, 2, 0);
      applyStimulus(1'b0, 32'h80020004, 2'b01, -1, 0, 0);

      // Sixteen words.
      for (int k = 0; k < 16; k++) vec[k] = 32'(k);
      applyStimulus(1'b1, 32'h80020040, 2'b11, -1, 0, 0);
      applyStimulus(1'b0, 32'h80020040, 2'b11, -1, 0, 0);

      // Rejected and boundary requests.
      applyReject(32'h80020002, 2'b00);
      applyReject(32'h8001FFFC, 2'b00);
      for (int k = 0; k < 4; k++) vec[k] = memDefault(wordIdx(32'h800FFFF8) + k);
      applyStimulus(1'b0, 32'h800FFFF8, 2'b01, -1, 0, 0);
      applyReject(32'h8011FFF8, 2'b01);

      // Read held off by 5 busy cycles.
      for (int k = 0; k < 4; k++) vec[k] = 32'h11111111 * 32'(k + 1);
      applyStimulus(1'b0, 32'h80020004, 2'b01, -1, 0, 5);

      // Reset on the third memory beat of an 8-word write.
      for (int k = 0; k < 8; k++) vec[k] = 32'hC0DE0000 + 32'(k);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h80020100;
      bus.req_write = 1'b1;
      bus.req_size  = 2'b10;
      @(negedge clock);
      bus.req_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.wr_data  = vec[k];
         bus.wr_valid = 1'b1;
         @(negedge clock);
      end
      bus.wr_valid = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge clock);
      checkOutput("wren_before_rst", 32'(bus.mem_wren), 32'd1);
      checkOutput("data_before_rst", bus.mem_data_in, vec[2]);
      reset_n = 1'b0;
      #1;
      checkOutput("wren_async_drop", 32'(bus.mem_wren), 32'd0);
      checkOutput("req_ready_in_rst", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checkOutput("req_ready_rerst", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         if (bus.done || bus.err || bus.mem_wren) eventCount = eventCount + 1;
         @(negedge clock);
      end
      checkOutput("no_done_err_after_rst", 32'(eventCount), 32'd0);
      checkOutput("req_ready_idle_end", 32'(bus.req_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
